// File: rtl/sys_cmd_ctrl_if.sv
// Host command bus: UART byte streams, register-file and ALU ports.
// master = command controller side, slave = UART/RF/ALU side.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [ADDR_WIDTH-1:0]   RF_ADDR;
  logic                    RF_WR_EN;
  logic [DATA_WIDTH-1:0]   RF_WR_DATA;
  logic                    RF_RD_EN;
  logic [DATA_WIDTH-1:0]   RF_RD_DATA;
  logic                    RF_RD_DATA_VLD;
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic                    ALU_CLK_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TX_BUSY;
  logic                    CTRL_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD,
    input  RF_RD_DATA, RF_RD_DATA_VLD,
    input  ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output RF_ADDR, RF_WR_EN, RF_WR_DATA,
    output RF_RD_EN, ALU_EN, ALU_FUN,
    output ALU_CLK_EN, TX_P_DATA, TX_D_VLD,
    output CTRL_BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD,
    output RF_RD_DATA, RF_RD_DATA_VLD,
    output ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  RF_ADDR, RF_WR_EN, RF_WR_DATA,
    input  RF_RD_EN, ALU_EN, ALU_FUN,
    input  ALU_CLK_EN, TX_P_DATA, TX_D_VLD,
    input  CTRL_BUSY
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Host command-frame decoder: AA write, BB read, CC/DD ALU ops,
// replies over UART TX. Ports: CLK, RST (async low), bus (master).
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  sys_cmd_ctrl_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA,
    S_RD_ADDR, S_RD_WAIT,
    S_ALU_A, S_ALU_B, S_ALU_FUN,
    S_ALU_WAIT, S_TX_REQ,
    S_TX_WAIT_HI, S_TX_WAIT_LO
  } state_t;

  state_t state, state_n;

  logic          rx;
  logic [DW-1:0] rxd;
  logic          tx_busy;

  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [3:0]      fun_q, fun_d;
  logic [DW-1:0]   txd_q, txd_d;
  logic [2*DW-1:0] resp_q, resp_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            en_q, en_d;
  logic            clken_q, clken_d;
  logic            txv_q, txv_d;
  logic            busy_q, busy_d;
  // more: response has a second byte; hi: now sending it
  logic            more_q, more_d;
  logic            hi_q, hi_d;

  assign rx      = bus.RX_D_VLD;
  assign rxd     = bus.RX_P_DATA;
  assign tx_busy = bus.TX_BUSY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fun_q   <= '0;
      txd_q   <= '0;
      resp_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      en_q    <= 1'b0;
      clken_q <= 1'b0;
      txv_q   <= 1'b0;
      busy_q  <= 1'b0;
      more_q  <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fun_q   <= fun_d;
      txd_q   <= txd_d;
      resp_q  <= resp_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      clken_q <= clken_d;
      txv_q   <= txv_d;
      busy_q  <= busy_d;
      more_q  <= more_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (rx) begin
          case (rxd)
            8'hAA:   state_n = S_WR_ADDR;
            8'hBB:   state_n = S_RD_ADDR;
            8'hCC:   state_n = S_ALU_A;
            8'hDD:   state_n = S_ALU_FUN;
            default: state_n = S_IDLE;
          endcase
        end
      end
      S_WR_ADDR:  if (rx) state_n = S_WR_DATA;
      S_WR_DATA:  if (rx) state_n = S_IDLE;
      S_RD_ADDR:  if (rx) state_n = S_RD_WAIT;
      S_RD_WAIT:
        if (bus.RF_RD_DATA_VLD) state_n = S_TX_REQ;
      S_ALU_A:    if (rx) state_n = S_ALU_B;
      S_ALU_B:    if (rx) state_n = S_ALU_FUN;
      S_ALU_FUN:  if (rx) state_n = S_ALU_WAIT;
      S_ALU_WAIT:
        if (bus.ALU_OUT_VLD) state_n = S_TX_REQ;
      S_TX_REQ:
        if (!tx_busy) state_n = S_TX_WAIT_HI;
      S_TX_WAIT_HI:
        if (tx_busy) state_n = S_TX_WAIT_LO;
      S_TX_WAIT_LO:
        if (!tx_busy)
          state_n = (more_q && !hi_q) ? S_TX_REQ
                                      : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fun_d   = fun_q;
    txd_d   = txd_q;
    resp_d  = resp_q;
    clken_d = clken_q;
    more_d  = more_q;
    hi_d    = hi_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    en_d    = 1'b0;
    txv_d   = 1'b0;
    case (state)
      S_WR_ADDR: if (rx) addr_d = rxd[AW-1:0];
      S_WR_DATA: begin
        if (rx) begin
          wr_d    = 1'b1;
          wdata_d = rxd;
        end
      end
      S_RD_ADDR: begin
        if (rx) begin
          rd_d   = 1'b1;
          addr_d = rxd[AW-1:0];
        end
      end
      S_RD_WAIT: begin
        if (bus.RF_RD_DATA_VLD) begin
          resp_d = {{DW{1'b0}}, bus.RF_RD_DATA};
          more_d = 1'b0;
          hi_d   = 1'b0;
        end
      end
      S_ALU_A: begin
        if (rx) begin
          wr_d    = 1'b1;
          addr_d  = '0;
          wdata_d = rxd;
        end
      end
      S_ALU_B: begin
        if (rx) begin
          wr_d    = 1'b1;
          addr_d  = AW'(1);
          wdata_d = rxd;
        end
      end
      S_ALU_FUN: begin
        if (rx) begin
          fun_d   = rxd[3:0];
          en_d    = 1'b1;
          clken_d = 1'b1;
        end
      end
      S_ALU_WAIT: begin
        if (bus.ALU_OUT_VLD) begin
          resp_d  = bus.ALU_OUT;
          clken_d = 1'b0;
          more_d  = 1'b1;
          hi_d    = 1'b0;
        end
      end
      S_TX_REQ: begin
        if (!tx_busy) begin
          txv_d = 1'b1;
          txd_d = hi_q ? resp_q[2*DW-1:DW]
                       : resp_q[DW-1:0];
        end
      end
      S_TX_WAIT_LO: begin
        if (!tx_busy && more_q && !hi_q)
          hi_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_n != S_IDLE);
  end

  assign bus.RF_ADDR    = addr_q;
  assign bus.RF_WR_EN   = wr_q;
  assign bus.RF_WR_DATA = wdata_q;
  assign bus.RF_RD_EN   = rd_q;
  assign bus.ALU_EN     = en_q;
  assign bus.ALU_FUN    = fun_q;
  assign bus.ALU_CLK_EN = clken_q;
  assign bus.TX_P_DATA  = txd_q;
  assign bus.TX_D_VLD   = txv_q;
  assign bus.CTRL_BUSY  = busy_q;
endmodule
